handle_remote_init_draw: RTL

Receive-side counterpart of the local initial-draw sequence. While the opponent board deals its 14 opening cards, this block consumes the decoded inter-board messages. For each draw it issues one map write and one card-pool take, and counts the draws. When `STATE_TURN` arrives it signals completion to the game controller.

---
 rtl/handle_remote_init_draw.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/handle_remote_init_draw.sv
// Receive side of the opening deal: applies the opponent's 14 DRAW_CARD messages as map writes plus card-pool takes.
// Latency: inter_en at N -> write/take strobes at N+1 -> remote_ready again at N+2; done pulses 1 cycle after STATE_TURN.
// Backpressure: remote_ready low outside WAIT_MSG/WAIT_TURN; messages arriving then are dropped. Optional checks: REMOTE_INIT_CHECK_EN.
module handle_remote_init_draw #(
    parameter bit         PLAYER            = 1'b0,  // 0 = P1, 1 = P2
    parameter logic [3:0] GAME_P1_INIT_DRAW = 4'd1,
    parameter logic [3:0] GAME_P2_INIT_DRAW = 4'd2,
    parameter logic [3:0] MSG_DRAW_CARD     = 4'd1,
    parameter logic [3:0] MSG_STATE_TURN    = 4'd2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         interboard_rst,
    input  logic         remote_init_en,
    input  logic [3:0]   cur_game_state,
    input  logic         inter_en,
    input  logic [3:0]   inter_msg_type,
    input  logic [5:0]   inter_card,
    input  logic [4:0]   inter_block_x,
    input  logic [2:0]   inter_block_y,
    input  logic [105:0] available_card,
    output logic         remote_ready,
    output logic         map_wr_en,
    output logic [4:0]   map_wr_x,
    output logic [2:0]   map_wr_y,
    output logic [5:0]   map_wr_card,
    output logic         card_take_en,
    output logic [5:0]   card_take_id,
    output logic [3:0]   draw_count,
    output logic         remote_init_done,
    output logic         remote_init_err
);

    localparam bit         P1         = 1'b0;
    localparam logic [3:0] INIT_DRAWS = 4'd14;

`ifdef REMOTE_INIT_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_MSG,
        S_APPLY,
        S_WAIT_TURN,
        S_FIN,
        S_ERR
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  hold_card_q, hold_card_d;
    logic [4:0]  hold_x_q, hold_x_d;
    logic [2:0]  hold_y_q, hold_y_d;
    logic [3:0]  draw_count_q, draw_count_d;

    logic        sync_rst;
    logic        opp_phase;
    logic        active;
    logic [6:0]  hi_idx;
    logic        card_present;
    logic        draw_bad;
    logic        apply_fire;

    assign sync_rst  = rst | interboard_rst;
    assign opp_phase = (PLAYER == P1) ? (cur_game_state == GAME_P2_INIT_DRAW)
                                      : (cur_game_state == GAME_P1_INIT_DRAW);
    assign active    = remote_init_en & opp_phase;

    // A card is in the pool if either of its two copy bits (card, card+53) is set.
    always_comb begin
        hi_idx       = {1'b0, inter_card} + 7'd53;
        card_present = available_card[inter_card];
        if (hi_idx < 7'd106) begin
            card_present = card_present | available_card[hi_idx];
        end
        draw_bad = CHECK_EN & ((inter_block_x > 5'd17) | ~card_present);
    end

    // Next-state and holding-register logic for the receive sequence.
    always_comb begin
        state_d      = state_q;
        hold_card_d  = hold_card_q;
        hold_x_d     = hold_x_q;
        hold_y_d     = hold_y_q;
        draw_count_d = draw_count_q;
        case (state_q)
            S_IDLE: begin
                draw_count_d = 4'd0;
                if (active) state_d = S_WAIT_MSG;
            end
            S_WAIT_MSG: begin
                if (!active) begin
                    state_d = S_IDLE;
                end else if (inter_en) begin
                    if (inter_msg_type == MSG_DRAW_CARD) begin
                        if (draw_bad) begin
                            state_d = S_ERR;
                        end else begin
                            hold_card_d = inter_card;
                            hold_x_d    = inter_block_x;
                            hold_y_d    = inter_block_y;
                            state_d     = S_APPLY;
                        end
                    end else if (CHECK_EN) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_APPLY: begin
                // The strobe fires this cycle regardless of where we go next.
                draw_count_d = draw_count_q + 4'd1;
                if (!active) begin
                    state_d = S_IDLE;
                end else if (CHECK_EN && inter_en) begin
                    state_d = S_ERR;
                end else if (draw_count_d == INIT_DRAWS) begin
                    state_d = S_WAIT_TURN;
                end else begin
                    state_d = S_WAIT_MSG;
                end
            end
            S_WAIT_TURN: begin
                if (!active) begin
                    state_d = S_IDLE;
                end else if (inter_en) begin
                    if (inter_msg_type == MSG_STATE_TURN) begin
                        state_d = S_FIN;
                    end else if (CHECK_EN) begin
                        state_d = S_ERR;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                if (!remote_init_en) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Single state register; either reset source wins over every transition.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q      <= S_IDLE;
            hold_card_q  <= 6'd0;
            hold_x_q     <= 5'd0;
            hold_y_q     <= 3'd0;
            draw_count_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            hold_card_q  <= hold_card_d;
            hold_x_q     <= hold_x_d;
            hold_y_q     <= hold_y_d;
            draw_count_q <= draw_count_d;
        end
    end

    // Strobes come from the APPLY state and holding registers; a reset in that cycle suppresses them.
    always_comb begin
        apply_fire   = (state_q == S_APPLY) & ~sync_rst;
        map_wr_en    = apply_fire;
        card_take_en = apply_fire;
        map_wr_x     = apply_fire ? hold_x_q    : 5'd0;
        map_wr_y     = apply_fire ? hold_y_q    : 3'd0;
        map_wr_card  = apply_fire ? hold_card_q : 6'd0;
        card_take_id = apply_fire ? hold_card_q : 6'd0;
    end

    assign remote_ready     = (state_q == S_WAIT_MSG) | (state_q == S_WAIT_TURN);
    assign draw_count       = draw_count_q;
    assign remote_init_done = (state_q == S_FIN);

`ifdef REMOTE_INIT_CHECK_EN
    assign remote_init_err = (state_q == S_ERR);
`else
    assign remote_init_err = 1'b0;
`endif

endmodule
